// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART frame sender:
//   - BYTE_W            : width of one serial byte (8)
//   - SYNC_BYTE_DEFAULT : default frame-start marker (8'hA5)
//   - ST_*              : frame sender FSM state encoding
//   - KIND_*            : which kind of byte is currently in flight
// Optional feature macro: FRAME_CHECKSUM_EN (adds the CKSUM state).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // FSM state encoding (plain constants so older flows can consume them)
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SYNC    = 4'd1;
    localparam logic [3:0] ST_FETCH   = 4'd2;
    localparam logic [3:0] ST_LATCH   = 4'd3;
    localparam logic [3:0] ST_SEND    = 4'd4;
    localparam logic [3:0] ST_WAIT_HI = 4'd5;
    localparam logic [3:0] ST_WAIT_LO = 4'd6;
    localparam logic [3:0] ST_NEXT    = 4'd7;
    localparam logic [3:0] ST_FINISH  = 4'd8;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [3:0] ST_CKSUM   = 4'd9;
`endif

    // Byte currently loaded in tx_data; steers NEXT and WAIT_LO
    localparam logic [1:0] KIND_SYNC  = 2'd0;
    localparam logic [1:0] KIND_PIXEL = 2'd1;
    localparam logic [1:0] KIND_CKSUM = 2'd2;

endpackage

// File: rtl/uart_frame_sender.sv
// -----------------------------------------------------------------------------
// uart_frame_sender
// Streams one image frame from a byte-wide frame memory to a UART transmitter:
// a sync marker byte, then FRAME_BYTES pixel bytes read from address 0 upward,
// and (with FRAME_CHECKSUM_EN defined) a trailing 8-bit additive checksum of
// the pixel bytes. One frame is sent per rising edge of start.
//
// Parameters:
//   FRAME_BYTES : pixel bytes per frame (must be <= 2**ADDR_W)
//   ADDR_W      : frame-memory address width
//   SYNC_BYTE   : frame-start marker byte
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   rising edge requests one frame (ignored while busy)
//   mem_rd    out  frame-memory read strobe (data valid one cycle later)
//   mem_addr  out  frame-memory byte address (0 when not reading)
//   mem_data  in   frame-memory read data
//   tx_data   out  byte to the transmitter, stable until tx_busy falls
//   tx_send   out  one-cycle send pulse to the transmitter
//   tx_busy   in   transmitter busy, rises one cycle after tx_send
//   busy      out  high from frame accept until frame completion
//   done      out  one-cycle pulse after the last byte has been shifted out
//
// Optional feature macro: FRAME_CHECKSUM_EN
// -----------------------------------------------------------------------------
module uart_frame_sender
    import uart_pkg::*;
#(
    parameter int                FRAME_BYTES = 4096,
    parameter int                ADDR_W      = 12,
    parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0] mem_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    logic [3:0]        state_reg;
    logic [3:0]        state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        kind_reg;
    logic [BYTE_W-1:0] tx_data_reg;
    logic              start_d_reg;
`ifdef FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] cksum_reg;
`endif

    logic start_edge;
    assign start_edge = start & ~start_d_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC:  state_next = ST_SEND;
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: state_next = ST_SEND;
            ST_SEND:  state_next = ST_WAIT_HI;
            // A transmitter that is already busy in SEND simply satisfies
            // this wait on the following cycle.
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
`ifdef FRAME_CHECKSUM_EN
                    state_next = (kind_reg == KIND_CKSUM) ? ST_FINISH : ST_NEXT;
`else
                    state_next = ST_NEXT;
`endif
                end
            end
            ST_NEXT: begin
                // After the sync byte the counter still points at pixel 0.
                if (kind_reg == KIND_SYNC || addr_reg < LAST_ADDR) begin
                    state_next = ST_FETCH;
                end else begin
`ifdef FRAME_CHECKSUM_EN
                    state_next = ST_CKSUM;
`else
                    state_next = ST_FINISH;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CKSUM: state_next = ST_SEND;
`endif
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            kind_reg    <= KIND_SYNC;
            tx_data_reg <= '0;
            start_d_reg <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            cksum_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            // Edge detector runs every cycle, so an edge seen while busy (or
            // in FINISH) is consumed and never replayed once IDLE is reached.
            start_d_reg <= start;
            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        addr_reg  <= '0;
`ifdef FRAME_CHECKSUM_EN
                        cksum_reg <= '0;
`endif
                    end
                end
                ST_SYNC: begin
                    tx_data_reg <= SYNC_BYTE;
                    kind_reg    <= KIND_SYNC;
                end
                ST_LATCH: begin
                    tx_data_reg <= mem_data;
                    kind_reg    <= KIND_PIXEL;
`ifdef FRAME_CHECKSUM_EN
                    cksum_reg   <= cksum_reg + mem_data;
`endif
                end
                ST_NEXT: begin
                    // Advance only after a pixel, and never past the last one.
                    if (kind_reg == KIND_PIXEL && addr_reg < LAST_ADDR) begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CKSUM: begin
                    tx_data_reg <= cksum_reg;
                    kind_reg    <= KIND_CKSUM;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs decoded from the state register (reset values follow
    // directly from the asynchronous state reset).
    // -------------------------------------------------------------------------
    assign mem_rd   = (state_reg == ST_FETCH);
    assign mem_addr = (state_reg == ST_FETCH) ? addr_reg : '0;
    assign tx_send  = (state_reg == ST_SEND);
    assign tx_data  = tx_data_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_uart_frame_sender.sv
`timescale 1ns/1ps
module tb_uart_frame_sender;

    localparam int NB = 4;
    localparam int AW = 2;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_busy;
    logic          busy;
    logic          done;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    int   bit_cnt    = 0;

    int checks   = 0;
    int failures = 0;
    int mon_err  = 0;
    int done_cnt = 0;

    logic [7:0] mem [NB];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         addr_q[$];

    assign tx_busy = model_busy | hold_busy;

    uart_frame_sender #(
        .FRAME_BYTES(NB),
        .ADDR_W     (AW),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Frame memory: registered read, data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem[mem_addr];
            addr_q.push_back(int'(mem_addr));
        end
    end

    // Transmitter: busy rises one cycle after tx_send, lasts a random time
    always @(posedge clk) begin
        if (tx_send) begin
            rx_q.push_back(tx_data);
            model_busy <= 1'b1;
            bit_cnt    <= int'($urandom_range(4, 12));
        end else if (bit_cnt > 0) begin
            bit_cnt <= bit_cnt - 1;
            if (bit_cnt == 1) model_busy <= 1'b0;
        end
    end

    // Protocol monitor on the transmitter interface
    int         low_run = 0;
    bit         prev_send = 0, seen_send = 0, hold_active = 0, seen_hi = 0;
    logic [7:0] held = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_send = 0; seen_send = 0; hold_active = 0; low_run = 0;
        end else begin
            if (done) done_cnt++;
            if (hold_active) begin
                if (tx_data !== held) begin
                    mon_err++;
                    $display("FAIL tx_data_stable: tx_data=%02h required=%02h", tx_data, held);
                    hold_active = 0;
                end else if (tx_busy) seen_hi = 1;
                else if (seen_hi) hold_active = 0;
            end
            if (tx_send) begin
                if (prev_send) begin
                    mon_err++;
                    $display("FAIL tx_send_width: tx_send high for more than 1 cycle, required 1");
                end else if (seen_send && low_run < 3) begin
                    mon_err++;
                    $display("FAIL tx_send_gap: low cycles=%0d required>=3", low_run);
                end
                low_run = 0; seen_send = 1; held = tx_data; hold_active = 1; seen_hi = tx_busy;
            end else begin
                low_run++;
            end
            prev_send = tx_send;
        end
    end

    // Reference: sync marker, pixels in address order, optional sum mod 256
    task automatic make_expected();
        int sum = 0;
        exp_q.delete();
        exp_q.push_back(SYNC);
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(mem[i]);
            sum += int'(mem[i]);
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic wait_done(input int budget, output bit seen, output int busy_low);
        seen = 0; busy_low = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (!busy) busy_low++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_send !== 1'b0) begin failures++; $display("FAIL reset_tx_send: got %0b required 0", tx_send); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %0b required 0", mem_rd); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b required 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %0b required 0", busy); end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_frame(input string name);
        bit seen;
        int busy_low, base;
        bit addr_ok;
        make_expected();
        rx_q.delete(); addr_q.delete();
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_accept: busy=%0b required 1", name, busy); end
        wait_done(2000, seen, busy_low);
        checks++; if (!seen) begin failures++; $display("FAIL %s_timeout: done not seen within 2000 cycles", name); end
        repeat (4) @(negedge clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_count: bytes=%0d required %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL %s_byte%0d: got %02h required %02h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (done_cnt - base != 1) begin failures++; $display("FAIL %s_done_count: got %0d required 1", name, done_cnt - base); end
        checks++; if (busy_low != 0) begin failures++; $display("FAIL %s_busy_held: busy low for %0d cycles required 0", name, busy_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end: got %0b required 0", name, busy); end
        addr_ok = (addr_q.size() == NB);
        for (int i = 0; i < addr_q.size() && addr_ok; i++) if (addr_q[i] != i) addr_ok = 0;
        checks++; if (!addr_ok) begin failures++; $display("FAIL %s_addresses: %0d reads not in order 0..%0d", name, addr_q.size(), NB - 1); end
        $display("frame %s: %0d bytes sent, first pixel %02h", name, rx_q.size(), mem[0]);
    endtask

    task automatic test_known_patterns();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        test_frame("seq01");
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'h02;
        test_frame("wrapsum");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
            test_frame($sformatf("rand%0d", n));
        end
    endtask

    task automatic test_start_held();
        bit seen;
        int busy_low, base, busy_after;
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        make_expected();
        rx_q.delete();
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        wait_done(2000, seen, busy_low);
        busy_after = 0;
        repeat (40) begin @(negedge clk); if (busy) busy_after++; end
        checks++; if (!seen) begin failures++; $display("FAIL held_timeout: done not seen within 2000 cycles"); end
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL held_count: bytes=%0d required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (done_cnt - base != 1) begin failures++; $display("FAIL held_done_count: got %0d required 1", done_cnt - base); end
        checks++; if (busy_after != 0) begin failures++; $display("FAIL held_no_restart: busy for %0d cycles required 0", busy_after); end
        $display("frame held: %0d bytes sent with start held high", rx_q.size());
        start = 1'b0;
        repeat (3) @(negedge clk);
        test_frame("held_second");
    endtask

    task automatic test_start_midframe();
        bit seen, found;
        int busy_low, base, busy_after;
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        make_expected();
        rx_q.delete();
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == AW'(2)) found = 1;
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(2000, seen, busy_low);
        busy_after = 0;
        repeat (40) begin @(negedge clk); if (busy) busy_after++; end
        checks++; if (!found) begin failures++; $display("FAIL mid_third_pixel: third pixel fetch not seen"); end
        checks++; if (!seen) begin failures++; $display("FAIL mid_timeout: done not seen within 2000 cycles"); end
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_count: bytes=%0d required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (done_cnt - base != 1) begin failures++; $display("FAIL mid_done_count: got %0d required 1", done_cnt - base); end
        checks++; if (busy_after != 0) begin failures++; $display("FAIL mid_not_queued: busy for %0d cycles required 0", busy_after); end
        $display("frame midstart: %0d bytes sent, extra start ignored", rx_q.size());
    endtask

    task automatic test_reset_midframe();
        bit found;
        int base, busy_after;
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        rx_q.delete();
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (rx_q.size() >= 3 && tx_busy) found = 1;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (!found) begin failures++; $display("FAIL rst_mid_reach: second pixel send not seen"); end
        checks++; if (tx_send !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== '0) begin
            failures++; $display("FAIL rst_mid_strobes: tx_send=%0b mem_rd=%0b mem_addr=%0d required 0 0 0", tx_send, mem_rd, mem_addr);
        end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_tx_data: got %02h required 00", tx_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_status: busy=%0b done=%0b required 0 0", busy, done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        busy_after = 0;
        repeat (30) begin @(negedge clk); if (busy) busy_after++; end
        checks++; if (busy_after != 0) begin failures++; $display("FAIL rst_mid_no_resume: busy for %0d cycles required 0", busy_after); end
        checks++; if (done_cnt != base) begin failures++; $display("FAIL rst_mid_no_done: done pulses=%0d required 0", done_cnt - base); end
        $display("frame aborted: reset after %0d bytes", rx_q.size());
        test_frame("after_reset");
    endtask

    task automatic test_busy_early();
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        hold_busy = 1'b1;
        fork
            begin
                repeat (15) @(negedge clk);
                hold_busy = 1'b0;
            end
        join_none
        test_frame("busy_early");
    endtask

    task automatic test_monitor();
        checks++;
        if (mon_err != 0) begin
            failures++; $display("FAIL tx_protocol: monitor violations=%0d required 0", mon_err);
        end
        $display("monitor: %0d protocol violations", mon_err);
    endtask

    initial begin
        test_reset();
        test_known_patterns();
        test_random_frames();
        test_start_held();
        test_start_midframe();
        test_reset_midframe();
        test_busy_early();
        test_monitor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 4096, meaning the number of pixel bytes per frame (64x64, 8-bit).
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning the frame-memory address width; FRAME_BYTES SHALL be at most 2**ADDR_W.
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame-start marker byte.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level or pulse; a rising edge requests one frame.
REQ-007 mem_rd  output  1  frame-memory read strobe.
REQ-008 mem_addr  output  ADDR_W  frame-memory byte address.
REQ-009 mem_data  input  8  frame-memory read data, valid exactly 1 cycle after mem_rd.
REQ-010 tx_data  output  8  byte to the UART transmitter; held stable from tx_send until tx_busy falls.
REQ-011 tx_send  output  1  one-cycle send pulse to the UART transmitter.
REQ-012 tx_busy  input  1  UART transmitter busy; it rises 1 cycle after tx_send.
REQ-013 busy  output  1  high from frame accept until frame completion.
REQ-014 done  output  1  one-cycle pulse after the last byte's stop bit completes.

Function
REQ-015 The FSM SHALL have states IDLE, SYNC, FETCH, LATCH, SEND, WAIT_HI, WAIT_LO, NEXT and FINISH.
REQ-016 In IDLE, a start rising edge (start & ~start_d) SHALL move to SYNC, set busy and clear the address counter and checksum.
REQ-017 SYNC SHALL load tx_data=SYNC_BYTE and go to SEND; the sync byte SHALL NOT be included in the checksum.
REQ-018 FETCH SHALL assert mem_rd for exactly one cycle with mem_addr equal to the counter value, then go to LATCH.
REQ-019 LATCH SHALL capture mem_data into tx_data, add it to the checksum (8-bit, modulo 256, wrap allowed), then go to SEND.
REQ-020 SEND SHALL assert tx_send for exactly one cycle, then go to WAIT_HI.
REQ-021 WAIT_HI SHALL wait for tx_busy=1, then go to WAIT_LO.
REQ-022 WAIT_LO SHALL wait for tx_busy=0, then go to NEXT.
REQ-023 NEXT SHALL go to FETCH while the counter is below FRAME_BYTES-1 (counter increments after each pixel), and otherwise go to FINISH.
REQ-024 NEXT SHALL go to FETCH after the sync byte, without incrementing the counter.
REQ-025 FINISH SHALL pulse done, clear busy and return to IDLE.
REQ-026 There SHALL be at least 3 cycles with tx_send low between consecutive tx_send pulses, so the transmitter's edge detector always sees a fresh edge.
REQ-027 A start edge while busy=1 SHALL be ignored and not queued; a start edge in the FINISH cycle SHALL also be ignored.
REQ-028 If tx_busy is already high in SEND, it SHALL be treated as WAIT_HI satisfied on the next cycle (no deadlock).
REQ-029 The address counter SHALL never exceed FRAME_BYTES-1, and mem_addr SHALL be 0 outside FETCH.
REQ-030 Total bytes per frame SHALL be FRAME_BYTES+1, or FRAME_BYTES+2 with the checksum feature enabled.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with tx_send=0, mem_rd=0, mem_addr=0, tx_data=8'h00, busy=0, done=0, checksum=0 and start_d=0.
REQ-032 Reset asserted mid-frame SHALL abort immediately with no done pulse, and the block SHALL require a new start edge after release.

Configuration
REQ-033 With FRAME_CHECKSUM_EN defined, NEXT after the last pixel SHALL go to a CKSUM state that loads tx_data=checksum, performs SEND/WAIT_HI/WAIT_LO, then goes to FINISH.
REQ-034 Without FRAME_CHECKSUM_EN, the CKSUM state and checksum register SHALL NOT exist, and FINISH SHALL follow the last pixel.

Structure
REQ-035 The shared package uart_pkg SHALL hold the FSM state encoding, the SYNC_BYTE default and the byte width constant (8).
REQ-036 The start edge detector SHALL be a single flop inline; no sub-module is required.
REQ-037 Simulation benches SHALL instantiate uart_frame_sender with the existing UART transmitter (CLK_FREQ=100_000_000, BAUD_RATE set high, e.g. 10_000_000, to shorten runs).

Verification
REQ-038 FRAME_BYTES=4, memory holding 8'h01,02,03,04, one start pulse -> serial bytes A5,01,02,03,04 (plus 0A with checksum enabled), one done pulse, busy high throughout.
REQ-039 Memory bytes FF,FF,FF,02 with checksum enabled -> checksum byte 8'h FF+FF+FF+02 mod 256 = 8'h FF.
REQ-040 Start held high for a whole frame -> exactly one frame is sent; a second frame is sent only after start goes low then high again.
REQ-041 Start pulse during the third pixel -> ignored; the byte count is unchanged and there is one done pulse.
REQ-042 rst_n driven low during WAIT_LO of the second pixel -> all outputs at reset values asynchronously and no done pulse; a later start gives a full frame from address 0.
REQ-043 Bench monitor: every tx_send is a 1-cycle pulse, separated by at least 3 low cycles, with tx_data stable until tx_busy falls.
